// File: rtl/ps2_scan_decode.sv
// PS/2 keyboard receiver: frame decoder plus make/break code tracker.
// Optional mid-frame timeout abort is built when PS2_TIMEOUT_EN is defined.
module ps2_scan_decode #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clck,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       extended
);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       parity_q, parity_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] key_code_q, key_code_d;
    logic       extended_q, extended_d;
    logic       brk_pend_q, brk_pend_d;
    logic       ext_pend_q, ext_pend_d;

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;
    logic       fall;
    logic       data_s;
    logic       frame_ok;

`ifdef PS2_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
`endif

    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_sync_q[1];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        key_code_d   = key_code_q;
        extended_d   = extended_q;
        brk_pend_d   = brk_pend_q;
        ext_pend_d   = ext_pend_q;
        frame_ok     = 1'b0;

        if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d = StData;
                        cnt_d   = 3'd0;
                    end
                end
                StData: begin
                    shift_d = {data_s, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = data_s;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    // Odd parity over data plus parity bit, and a high stop bit.
                    if (data_s && (^{shift_q, parity_q})) frame_ok = 1'b1;
                    else frame_err_d = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end

`ifdef PS2_TIMEOUT_EN
        to_cnt_d = 32'd0;
        if (state_q != StIdle && !fall) begin
            if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
                state_d     = StIdle;
                frame_err_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end
`endif

        if (frame_ok) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            if (shift_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                if (!brk_pend_q) begin
                    key_code_d = shift_q;
                    extended_d = ext_pend_q;
                end else if (shift_q == key_code_q && ext_pend_q == extended_q) begin
                    key_code_d = 8'h00;
                    extended_d = 1'b0;
                end
                brk_pend_d = 1'b0;
                ext_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clck) begin
        if (!reset_n) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_prev_q   <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            shift_q      <= 8'h00;
            parity_q     <= 1'b0;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            key_code_q   <= 8'h00;
            extended_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[0], ps2_clk};
            data_sync_q  <= {data_sync_q[0], ps2_data};
            clk_prev_q   <= clk_sync_q[1];
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            key_code_q   <= key_code_d;
            extended_q   <= extended_d;
            brk_pend_q   <= brk_pend_d;
            ext_pend_q   <= ext_pend_d;
        end
    end

`ifdef PS2_TIMEOUT_EN
    always_ff @(posedge clck) begin
        if (!reset_n) to_cnt_q <= 32'd0;
        else          to_cnt_q <= to_cnt_d;
    end
`endif

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign key_code   = key_code_q;
    assign extended   = extended_q;

endmodule

// File: tb/tb_ps2_scan_decode.sv
// Scoreboard bench for ps2_scan_decode: stimulus queues expected pulses, a monitor checks them.
module tb_ps2_scan_decode;

    logic       clck = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] key_code;
    logic       extended;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       err;
        logic [7:0] bd;
        logic [7:0] kc;
        logic       ex;
    } exp_t;

    exp_t exp_q[$];

    ps2_scan_decode #(.TIMEOUT_CYCLES(64)) dut (
        .clck      (clck),
        .reset_n   (reset_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .key_code  (key_code),
        .extended  (extended)
    );

    always #5 clck = ~clck;

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clck) begin
        if (byte_valid || frame_err) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: valid=%b err=%b byte=%h key=%h ext=%b, none expected",
                         byte_valid, frame_err, byte_data, key_code, extended);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (frame_err !== e.err || byte_valid !== !e.err || byte_data !== e.bd ||
                    key_code !== e.kc || extended !== e.ex) begin
                    bad++;
                    $display("FAIL pulse: got err=%b valid=%b byte=%h key=%h ext=%b, want err=%b byte=%h key=%h ext=%b",
                             frame_err, byte_valid, byte_data, key_code, extended,
                             e.err, e.bd, e.kc, e.ex);
                end
            end
        end
    end

    task automatic expect_ev(input logic err, input logic [7:0] bd, input logic [7:0] kc,
                             input logic ex);
        exp_t e;
        e.err = err; e.bd = bd; e.kc = kc; e.ex = ex;
        exp_q.push_back(e);
    endtask

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        #50;
        ps2_clk = 1'b0;
        #100;
        ps2_clk = 1'b1;
        #50;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
        logic [10:0] bits;
        bits = {stop, (par_ok ? ~^b : ^b), b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        #200;
    endtask

    task automatic good(input logic [7:0] b, input logic [7:0] kc, input logic ex);
        expect_ev(1'b0, b, kc, ex);
        send_frame(b, 1'b1, 1'b1);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_byte_data"}, byte_data, 8'h00);
        check({tag, "_byte_valid"}, {7'd0, byte_valid}, 8'h00);
        check({tag, "_frame_err"}, {7'd0, frame_err}, 8'h00);
        check({tag, "_key_code"}, key_code, 8'h00);
        check({tag, "_extended"}, {7'd0, extended}, 8'h00);
    endtask

    initial begin
        logic [10:0] part;
        repeat (5) @(negedge clck);
        check_reset_state("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clck);

        good(8'h24, 8'h24, 1'b0);

`ifdef PS2_TIMEOUT_EN
        // Start bit plus four data bits, then silence until the timeout fires.
        expect_ev(1'b1, 8'h24, 8'h24, 1'b0);
        part = {2'b11, 8'h24, 1'b0};
        for (int i = 0; i < 5; i++) ps2_bit(part[i]);
        #1500;
        good(8'h24, 8'h24, 1'b0);
`endif

        // Make then break of 0x2D.
        good(8'h2D, 8'h2D, 1'b0);
        good(8'hF0, 8'h2D, 1'b0);
        good(8'h2D, 8'h00, 1'b0);

        // Bad parity keeps key_code and byte_data.
        good(8'h24, 8'h24, 1'b0);
        expect_ev(1'b1, 8'h24, 8'h24, 1'b0);
        send_frame(8'h24, 1'b0, 1'b1);

        // Extended make/break.
        good(8'hE0, 8'h24, 1'b0);
        good(8'h75, 8'h75, 1'b1);
        good(8'hE0, 8'h75, 1'b1);
        good(8'hF0, 8'h75, 1'b1);
        good(8'h75, 8'h00, 1'b0);

        // Break of a different key, or with mismatched prefix, leaves key held.
        good(8'h1C, 8'h1C, 1'b0);
        good(8'h1C, 8'h1C, 1'b0);
        good(8'hF0, 8'h1C, 1'b0);
        good(8'h32, 8'h1C, 1'b0);
        good(8'hE0, 8'h1C, 1'b0);
        good(8'hF0, 8'h1C, 1'b0);
        good(8'h1C, 8'h1C, 1'b0);

        // Bad stop bit.
        expect_ev(1'b1, 8'h1C, 8'h1C, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);

        good(8'hF0, 8'h1C, 1'b0);
        good(8'h1C, 8'h00, 1'b0);
        good(8'h3A, 8'h3A, 1'b0);

        // Reset after five bits of a frame discards it silently.
        part = {2'b11, 8'h3A, 1'b0};
        for (int i = 0; i < 5; i++) ps2_bit(part[i]);
        #100;
        @(negedge clck);
        reset_n = 1'b0;
        @(negedge clck);
        reset_n = 1'b1;
        check_reset_state("midreset");
        repeat (5) @(negedge clck);
        check_reset_state("postreset");
        good(8'h2D, 8'h2D, 1'b0);

        #1000;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: %0d outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ps2_scan_decode.md
PS2_SCAN_DECODE -- requirements
Module: ps2_scan_decode

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, idle clck cycles mid-frame before abort (used only with PS2_TIMEOUT_EN).
REQ-002 SHALL have port clck  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clck.
REQ-005 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clck.
REQ-006 SHALL have port byte_data  output  8  last correctly received frame byte.
REQ-007 SHALL have port byte_valid  output  1  one-cycle pulse marking a new byte_data.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a bad or aborted frame.
REQ-009 SHALL have port key_code  output  8  make code of the currently held key, 0x00 if none; feeds the downstream play_signal input.
REQ-010 SHALL have port extended  output  1  key_code was preceded by the 0xE0 prefix.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through two flops; a falling edge means previous synced clock = 1 and current synced clock = 0.
REQ-012 SHALL run a receiver FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on a detected falling edge.
REQ-013 IDLE: on an edge with data=0 (start bit) SHALL go to DATA with bit count 0; with data=1 SHALL stay IDLE with no pulse.
REQ-014 DATA: SHALL shift 8 bits LSB first, going to PARITY after the 8th bit (count 0..7).
REQ-015 PARITY: SHALL sample the parity bit; the frame is valid only if the 8 data bits plus parity hold an odd number of ones.
REQ-016 STOP: on the edge, if stop=1 and parity is good, SHALL load byte_data and pulse byte_valid in the following clck cycle; otherwise SHALL pulse frame_err in that cycle and leave byte_data unchanged; SHALL return to IDLE either way.
REQ-017 Latency: stop-bit edge detected in cycle N -> byte_valid/frame_err high in cycle N+1 only; key_code/extended updated in the same cycle N+1.
REQ-018 Code tracker flags break_pending and ext_pending, both cleared after any non-prefix byte is consumed.
REQ-019 Valid byte 0xE0 SHALL set ext_pending; 0xF0 SHALL set break_pending; neither changes key_code.
REQ-020 Other valid byte, break_pending=0: key_code <= byte, extended <= ext_pending (typematic repeats rewrite the same value).
REQ-021 Other valid byte, break_pending=1: if byte equals key_code and ext_pending equals extended, key_code <= 0x00 and extended <= 0; else key_code is unchanged.
REQ-022 frame_err SHALL leave key_code, extended, and both pending flags unchanged.

Reset
REQ-023 With reset_n=0 at a clck edge: FSM to IDLE, bit count 0, shift register 0, byte_data=0x00, byte_valid=0, frame_err=0, key_code=0x00, extended=0, pending flags 0, sync flops to 1 (idle bus), timeout counter 0.
REQ-024 Reset mid-frame SHALL discard the partial frame without a frame_err pulse; the next start bit SHALL decode normally.

Configuration
REQ-025 Macro PS2_TIMEOUT_EN defined: outside IDLE, a counter SHALL clear on each falling edge and otherwise increment; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE and pulse frame_err the next cycle.
REQ-026 Macro PS2_TIMEOUT_EN undefined: no counter is built; a partial frame persists in its state indefinitely until further edges arrive.

Verification
REQ-027 Frame 0x24 (start 0, bits 00100100 LSB first, parity 1, stop 1) -> one byte_valid with byte_data=0x24, key_code=0x24, extended=0.
REQ-028 Frames 0x2D, then 0xF0, then 0x2D -> key_code 0x2D after the first byte, still 0x2D after 0xF0, 0x00 after the final byte; three byte_valid pulses.
REQ-029 Frame 0x24 sent with parity 0 -> frame_err pulses once, no byte_valid, key_code keeps its prior value.
REQ-030 Frames 0xE0 (parity 0), then 0x75 -> key_code=0x75, extended=1; then 0xE0, 0xF0, 0x75 -> key_code=0x00, extended=0.
REQ-031 With PS2_TIMEOUT_EN and TIMEOUT_CYCLES=64: start bit plus 4 data bits, then silence -> frame_err pulse 64 cycles after the last edge, FSM in IDLE; a following full 0x24 frame decodes correctly.
REQ-032 reset_n low for 1 cycle after 5 bits of a frame -> all outputs read reset values, no pulses; the next 0x2D frame gives key_code=0x2D.
